// File: rtl/histo_report_packetizer.sv
// Captures a frame readout and the top-3 sort result, then streams one byte-wide report packet.
// Optional checksum byte at the packet tail is enabled by defining PKT_CSUM_EN.
module histo_report_packetizer #(
  parameter int          DATA_SIZE   = 4,
  parameter int          LENGTH      = 64,
  parameter int          LENGTH_SIZE = 6,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   FramEn,
  input  logic [LENGTH_SIZE-1:0] FramAdd,
  input  logic [DATA_SIZE-1:0]   FramData,
  input  logic                   SortValid,
  input  logic [DATA_SIZE-1:0]   MaxCountData1,
  input  logic [DATA_SIZE-1:0]   MaxCountData2,
  input  logic [DATA_SIZE-1:0]   MaxCountData3,
  input  logic [LENGTH_SIZE-1:0] MaxCount1,
  input  logic [LENGTH_SIZE-1:0] MaxCount2,
  input  logic [LENGTH_SIZE-1:0] MaxCount3,
  output logic [7:0]             OutData,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic                   OutLast,
  output logic                   Busy,
  output logic                   Overrun
);

  localparam int                     FIDX_W    = LENGTH_SIZE - 1;
  localparam logic [FIDX_W-1:0]      FIDX_LAST = FIDX_W'(LENGTH/2 - 1);
  localparam logic [LENGTH_SIZE-1:0] FCNT_LAST = LENGTH_SIZE'(LENGTH - 1);

  typedef enum logic [2:0] {
    CAPTURE, SEND_HDR, SEND_TOP, SEND_FRAME
`ifdef PKT_CSUM_EN
    , SEND_CSUM
`endif
  } state_t;

  typedef struct packed {
    logic [DATA_SIZE-1:0]   data;
    logic [LENGTH_SIZE-1:0] count;
  } topEntry_t;

  state_t state, nextState;

  logic [LENGTH-1:0][DATA_SIZE-1:0] buffer;
  topEntry_t [2:0]                  topLatch;
  logic [LENGTH_SIZE-1:0]           frameCnt;
  logic                             frameDone, sortDone;
  logic [2:0]                       topIdx;
  logic [FIDX_W-1:0]                frameIdx;
  logic                             capturing, frameHit, goSend, xfer;
  topEntry_t                        topSel;
  logic [7:0]                       topByte, frameByte;

  assign capturing = (state == CAPTURE);
  assign frameHit  = FramEn && (frameCnt == FCNT_LAST);
  // Launch in the cycle right after the last missing input is sampled.
  assign goSend    = capturing && (frameDone || frameHit) && (sortDone || SortValid);
  assign OutValid  = !capturing;
  assign Busy      = !capturing;
  assign xfer      = OutValid && OutReady;

  assign topSel    = topLatch[topIdx[2:1]];
  assign topByte   = topIdx[0] ? 8'(topSel.count) : 8'(topSel.data);
  assign frameByte = {buffer[{frameIdx, 1'b1}], buffer[{frameIdx, 1'b0}]};

`ifdef PKT_CSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (!rstn)                                              csum <= 8'h00;
    else if (state == SEND_HDR)                             csum <= 8'h00;
    else if (xfer && (state == SEND_TOP || state == SEND_FRAME)) csum <= csum + OutData;
  end

  assign OutLast = (state == SEND_CSUM);
`else
  assign OutLast = (state == SEND_FRAME) && (frameIdx == FIDX_LAST);
`endif

  always_comb begin
    OutData = 8'h00;
    unique case (state)
      SEND_HDR:   OutData = HEADER;
      SEND_TOP:   OutData = topByte;
      SEND_FRAME: OutData = frameByte;
`ifdef PKT_CSUM_EN
      SEND_CSUM:  OutData = csum;
`endif
      default:    OutData = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= CAPTURE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      CAPTURE:    if (goSend)                          nextState = SEND_HDR;
      SEND_HDR:   if (xfer)                            nextState = SEND_TOP;
      SEND_TOP:   if (xfer && topIdx == 3'd5)          nextState = SEND_FRAME;
`ifdef PKT_CSUM_EN
      SEND_FRAME: if (xfer && frameIdx == FIDX_LAST)   nextState = SEND_CSUM;
      SEND_CSUM:  if (xfer)                            nextState = CAPTURE;
`else
      SEND_FRAME: if (xfer && frameIdx == FIDX_LAST)   nextState = CAPTURE;
`endif
      default:                                         nextState = CAPTURE;
    endcase
  end

  // Capture bookkeeping; counters and flags restart on packet launch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      frameCnt  <= '0;
      frameDone <= 1'b0;
      sortDone  <= 1'b0;
    end else if (goSend) begin
      frameCnt  <= '0;
      frameDone <= 1'b0;
      sortDone  <= 1'b0;
    end else if (capturing) begin
      if (FramEn)    frameCnt  <= frameCnt + 1'b1;
      if (frameHit)  frameDone <= 1'b1;
      if (SortValid) sortDone  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capturing && FramEn) buffer[FramAdd] <= FramData;
    if (capturing && SortValid) begin
      topLatch[0] <= '{data: MaxCountData1, count: MaxCount1};
      topLatch[1] <= '{data: MaxCountData2, count: MaxCount2};
      topLatch[2] <= '{data: MaxCountData3, count: MaxCount3};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      topIdx   <= '0;
      frameIdx <= '0;
      Overrun  <= 1'b0;
    end else begin
      if (state != SEND_TOP)   topIdx   <= '0;
      else if (xfer)           topIdx   <= topIdx + 1'b1;
      if (state != SEND_FRAME) frameIdx <= '0;
      else if (xfer)           frameIdx <= frameIdx + 1'b1;
      if (!capturing && (FramEn || SortValid)) Overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_histo_report_packetizer.sv
// Directed bench for histo_report_packetizer: nominal, backpressure, order, overrun, mid-packet reset.
// Follows PKT_CSUM_EN so the same bench covers both packet lengths.
module tb_histo_report_packetizer;

`ifdef PKT_CSUM_EN
  localparam int NB = 40;
`else
  localparam int NB = 39;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       FramEn = 1'b0;
  logic [5:0] FramAdd = '0;
  logic [3:0] FramData = '0;
  logic       SortValid = 1'b0;
  logic [3:0] MaxCountData1 = '0, MaxCountData2 = '0, MaxCountData3 = '0;
  logic [5:0] MaxCount1 = '0, MaxCount2 = '0, MaxCount3 = '0;
  logic [7:0] OutData;
  logic       OutValid, OutReady = 1'b1, OutLast, Busy, Overrun;

  int nTests = 0;
  int nFail  = 0;
  logic [7:0] expPkt [0:39];

  always #5 clk = ~clk;

  histo_report_packetizer dut (
    .clk(clk), .rstn(rstn), .FramEn(FramEn), .FramAdd(FramAdd), .FramData(FramData),
    .SortValid(SortValid), .MaxCountData1(MaxCountData1), .MaxCountData2(MaxCountData2),
    .MaxCountData3(MaxCountData3), .MaxCount1(MaxCount1), .MaxCount2(MaxCount2),
    .MaxCount3(MaxCount3), .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .OutLast(OutLast), .Busy(Busy), .Overrun(Overrun)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-written packet images: nominal ramp data, or all-zero data.
  task automatic buildExp(input bit zero);
    logic [7:0] grp [0:7];
    logic [7:0] top [0:5];
    grp = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
    top = '{8'h07, 8'h14, 8'h03, 8'h0C, 8'h00, 8'h05};
    expPkt[0] = 8'hA5;
    for (int i = 0; i < 6; i++)  expPkt[1+i] = zero ? 8'h00 : top[i];
    for (int j = 0; j < 32; j++) expPkt[7+j] = zero ? 8'h00 : grp[j%8];
    expPkt[39] = zero ? 8'h00 : 8'h0F;
  endtask

  task automatic loadFrame(input int first, input int last, input bit zero);
    for (int a = first; a <= last; a++) begin
      FramEn = 1'b1; FramAdd = 6'(a); FramData = zero ? 4'h0 : 4'(a);
      tick();
    end
    FramEn = 1'b0;
  endtask

  task automatic sortPulse(input bit zero);
    SortValid = 1'b1;
    MaxCountData1 = zero ? 4'd0 : 4'd7; MaxCount1 = zero ? 6'd0 : 6'd20;
    MaxCountData2 = zero ? 4'd0 : 4'd3; MaxCount2 = zero ? 6'd0 : 6'd12;
    MaxCountData3 = 4'd0;               MaxCount3 = zero ? 6'd0 : 6'd5;
    tick();
    SortValid = 1'b0;
  endtask

  // Receives bytes until stopAt transfers; mode 1 toggles OutReady 1,0,0;
  // injectAt >= 0 pushes a FramEn+SortValid while that byte is pending.
  task automatic recvPacket(input string name, input int stopAt, input int mode, input int injectAt);
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [7:0] hd = '0;
    logic hl = 1'b0;
    while (k < stopAt && cyc < 400) begin
      OutReady = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (k == injectAt) begin
        FramEn = 1'b1; FramAdd = 6'd62; FramData = 4'h0; SortValid = 1'b1;
      end else begin
        FramEn = 1'b0; SortValid = 1'b0;
      end
      checkVal($sformatf("%s valid c%0d", name, cyc), OutValid, 1'b1);
      if (stalled) begin
        checkVal($sformatf("%s holdData c%0d", name, cyc), OutData, hd);
        checkVal($sformatf("%s holdLast c%0d", name, cyc), OutLast, hl);
      end
      if (OutValid && OutReady) begin
        checkVal($sformatf("%s byte%0d", name, k), OutData, expPkt[k]);
        checkVal($sformatf("%s last%0d", name, k), OutLast, (k == NB-1));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1; hd = OutData; hl = OutLast;
      end
      tick();
      cyc++;
    end
    FramEn = 1'b0; SortValid = 1'b0; OutReady = 1'b1;
    if (k < stopAt) checkVal($sformatf("%s timeout", name), k, stopAt);
    if (stopAt == NB) begin
      if (mode == 0) checkVal($sformatf("%s cycles", name), cyc, NB);
      checkVal($sformatf("%s endValid", name), OutValid, 1'b0);
      checkVal($sformatf("%s endBusy", name), Busy, 1'b0);
      checkVal($sformatf("%s endLast", name), OutLast, 1'b0);
    end
  endtask

  initial begin
    rstn = 1'b0;
    tick(); tick();
    checkVal("rst OutValid", OutValid, 1'b0);
    checkVal("rst OutLast", OutLast, 1'b0);
    checkVal("rst OutData", OutData, 8'h00);
    checkVal("rst Busy", Busy, 1'b0);
    checkVal("rst Overrun", Overrun, 1'b0);
    rstn = 1'b1;
    tick();

    // Nominal
    buildExp(1'b0);
    loadFrame(0, 63, 1'b0);
    checkVal("nom idle", OutValid, 1'b0);
    sortPulse(1'b0);
    checkVal("nom start", OutValid, 1'b1);
    checkVal("nom busy", Busy, 1'b1);
    recvPacket("nom", NB, 0, -1);

    // Backpressure
    loadFrame(0, 63, 1'b0);
    sortPulse(1'b0);
    recvPacket("bp", NB, 1, -1);
    checkVal("bp Overrun", Overrun, 1'b0);

    // Order independence: sort first, frame completes later
    sortPulse(1'b0);
    tick(); tick(); tick();
    loadFrame(0, 62, 1'b0);
    checkVal("ord early", OutValid, 1'b0);
    loadFrame(63, 63, 1'b0);
    checkVal("ord start", OutValid, 1'b1);
    checkVal("ord hdr", OutData, 8'hA5);
    recvPacket("ord", NB, 0, -1);

    // Overrun during SEND_FRAME; packet must be unaffected
    loadFrame(0, 63, 1'b0);
    sortPulse(1'b0);
    recvPacket("ovr", NB, 0, 10);
    checkVal("ovr set", Overrun, 1'b1);
    buildExp(1'b1);
    loadFrame(0, 62, 1'b1);
    checkVal("ovr early", OutValid, 1'b0);
    loadFrame(63, 63, 1'b1);
    sortPulse(1'b1);
    recvPacket("zero", NB, 0, -1);
    checkVal("ovr sticky", Overrun, 1'b1);

    // Reset mid-packet
    buildExp(1'b0);
    loadFrame(0, 63, 1'b0);
    sortPulse(1'b0);
    recvPacket("mid", 12, 0, -1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checkVal("midrst OutValid", OutValid, 1'b0);
    checkVal("midrst Busy", Busy, 1'b0);
    checkVal("midrst Overrun", Overrun, 1'b0);
    checkVal("midrst OutData", OutData, 8'h00);
    sortPulse(1'b0);
    for (int i = 0; i < 5; i++) begin
      checkVal($sformatf("midrst quiet%0d", i), OutValid, 1'b0);
      tick();
    end
    loadFrame(0, 62, 1'b0);
    checkVal("midrst early", OutValid, 1'b0);
    loadFrame(63, 63, 1'b0);
    checkVal("midrst start", OutValid, 1'b1);
    recvPacket("post", NB, 0, -1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
